game_timer_board: RTL and testbench

GAME_TIMER_BOARD -- requirements
Module: game_timer_board

---
 rtl/game_pkg.sv | 24 ++
 rtl/bin2bcd_seq.sv | 85 ++++++++
 rtl/game_timer_board.sv | 158 +++++++++++++++
 tb/tb_game_timer_board.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared types, constants and helpers for the game timer / leaderboard block.
package game_pkg;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      SHIFT,
      DONE
   } cvt_state_e;

   localparam logic [3:0] BLANK_NIBBLE = 4'hF;

   // Largest seconds value that fits SEC_W bits and still shows on DIGITS decimal digits.
   function automatic longint sat_limit(input int sec_w, input int digits);
      longint bin_max;
      longint dec_max;
      bin_max = (longint'(1) << sec_w) - 1;
      dec_max = 1;
      for (int i = 0; i < digits; i++) dec_max = dec_max * 10;
      dec_max = dec_max - 1;
      return (bin_max < dec_max) ? bin_max : dec_max;
   endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary to BCD converter, one bit per cycle.
// state | meaning
// IDLE  | waiting for start_i, bcd_o holds last result
// LOAD  | latch din_i, clear accumulator
// SHIFT | SEC_W adjust-and-shift steps
// DONE  | result presented on bcd_o, written back on exit
module bin2bcd_seq
   import game_pkg::*;
#(
   parameter int SEC_W  = 14,
   parameter int DIGITS = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start_i,
   input  logic [SEC_W-1:0]    din_i,
   output logic                busy_o,
   output logic                done_o,
   output logic [4*DIGITS-1:0] bcd_o
);
   localparam int CW = $clog2(SEC_W + 1);

   cvt_state_e          state_q, state_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [SEC_W-1:0]    bin_q, bin_d, bin_sh;
   logic [4*DIGITS-1:0] acc_q, acc_d, acc_adj, acc_sh;
   logic [4*DIGITS-1:0] bcd_q, bcd_d;

   always_comb begin
      acc_adj = acc_q;
      for (int k = 0; k < DIGITS; k++) begin
         if (acc_q[4*k +: 4] >= 4'd5) acc_adj[4*k +: 4] = acc_q[4*k +: 4] + 4'd3;
      end
      {acc_sh, bin_sh} = {acc_adj, bin_q} << 1;
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bin_d   = bin_q;
      acc_d   = acc_q;
      bcd_d   = bcd_q;
      unique case (state_q)
         IDLE: if (start_i) state_d = LOAD;
         LOAD: begin
            bin_d   = din_i;
            acc_d   = '0;
            cnt_d   = CW'(SEC_W - 1);
            state_d = SHIFT;
         end
         SHIFT: begin
            bin_d = bin_sh;
            acc_d = acc_sh;
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == '0) state_d = DONE;
         end
         DONE: begin
            bcd_d   = acc_q;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         bin_q   <= '0;
         acc_q   <= '0;
         bcd_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bin_q   <= bin_d;
         acc_q   <= acc_d;
         bcd_q   <= bcd_d;
      end
   end

   assign busy_o = (state_q != IDLE);
   assign done_o = (state_q == DONE);
   assign bcd_o  = done_o ? acc_q : bcd_q;

endmodule

// File: rtl/game_timer_board.sv
// Elapsed-seconds timer with a sorted best-times leaderboard and a BCD display mux.
module game_timer_board
   import game_pkg::*;
#(
   parameter int TICK_DIV = 100000000,
   parameter int DIGITS   = 4,
   parameter int SEC_W    = 14,
   parameter int RANKS    = 3
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                run_i,
   input  logic                clear_i,
   input  logic                commit_i,
   input  logic [3:0]          sel_i,
   output logic [4*DIGITS-1:0] bcd_o,
   output logic                blank_o,
   output logic                bcd_valid_o,
   output logic                new_record_o,
   output logic [3:0]          last_rank_o
);
   localparam int               PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0]    PRESC_LAST = PW'(TICK_DIV - 1);
   localparam logic [SEC_W-1:0] SEC_MAX    = SEC_W'(sat_limit(SEC_W, DIGITS));

   logic [PW-1:0]    presc_q, presc_d;
   logic [SEC_W-1:0] sec_q, sec_d;
   logic             tick;
   logic [SEC_W-1:0] val_q [RANKS];
   logic [SEC_W-1:0] val_d [RANKS];
   logic [RANKS-1:0] vld_q, vld_d;
   logic             ins_found;
   logic [3:0]       ins_idx;
   logic             new_record_q, new_record_d;
   logic [3:0]       last_rank_q, last_rank_d;
   logic [SEC_W-1:0] src_val, snap_val_q;
   logic [3:0]       snap_sel_q;
   logic             snap_vld_q, blank_now, blank_q, mismatch, start;
   logic             conv_ok_q, cvt_busy, cvt_done;
   logic [4*DIGITS-1:0] cvt_bcd;

   always_comb begin
      tick    = run_i && (presc_q == PRESC_LAST);
      presc_d = presc_q;
      sec_d   = sec_q;
      if (clear_i) begin
         presc_d = '0;
         sec_d   = '0;
      end else if (run_i) begin
         presc_d = tick ? '0 : presc_q + 1'b1;
         if (tick && (sec_q != SEC_MAX)) sec_d = sec_q + 1'b1;
      end
   end

   // Ties land behind an equal entry because only a strictly larger value is displaced.
   always_comb begin
      ins_found = 1'b0;
      ins_idx   = '0;
      for (int r = 0; r < RANKS; r++) begin
         if (!ins_found && (!vld_q[r] || (val_q[r] > sec_q))) begin
            ins_found = 1'b1;
            ins_idx   = 4'(r);
         end
      end
      val_d        = val_q;
      vld_d        = vld_q;
      new_record_d = 1'b0;
      last_rank_d  = last_rank_q;
      if (commit_i) begin
         last_rank_d  = ins_found ? ins_idx + 4'd1 : 4'd0;
         new_record_d = ins_found && (ins_idx == 4'd0);
         if (ins_found) begin
            for (int r = RANKS - 1; r > 0; r--) begin
               if (4'(r) > ins_idx) begin
                  val_d[r] = val_q[r-1];
                  vld_d[r] = vld_q[r-1];
               end
            end
            for (int r = 0; r < RANKS; r++) begin
               if (4'(r) == ins_idx) begin
                  val_d[r] = sec_q;
                  vld_d[r] = 1'b1;
               end
            end
         end
      end
   end

   always_comb begin
      src_val   = sec_q;
      blank_now = 1'b0;
      if (sel_i != 4'd0) begin
         src_val   = '0;
         blank_now = 1'b1;
         for (int r = 0; r < RANKS; r++) begin
            if (sel_i == 4'(r + 1)) begin
               src_val   = val_q[r];
               blank_now = !vld_q[r];
            end
         end
      end
      mismatch = !snap_vld_q || (snap_val_q != src_val) || (snap_sel_q != sel_i);
      start    = !cvt_busy && mismatch && !blank_now;
   end

   bin2bcd_seq #(
      .SEC_W  (SEC_W),
      .DIGITS (DIGITS)
   ) u_bin2bcd (
      .clk     (clk),
      .rst     (rst),
      .start_i (start),
      .din_i   (snap_val_q),
      .busy_o  (cvt_busy),
      .done_o  (cvt_done),
      .bcd_o   (cvt_bcd)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         presc_q      <= '0;
         sec_q        <= '0;
         vld_q        <= '0;
         for (int r = 0; r < RANKS; r++) val_q[r] <= '0;
         new_record_q <= 1'b0;
         last_rank_q  <= '0;
         snap_val_q   <= '0;
         snap_sel_q   <= '0;
         snap_vld_q   <= 1'b0;
         conv_ok_q    <= 1'b0;
         blank_q      <= 1'b0;
      end else begin
         presc_q      <= presc_d;
         sec_q        <= sec_d;
         vld_q        <= vld_d;
         val_q        <= val_d;
         new_record_q <= new_record_d;
         last_rank_q  <= last_rank_d;
         blank_q      <= blank_now;
         if (start) begin
            snap_val_q <= src_val;
            snap_sel_q <= sel_i;
            snap_vld_q <= 1'b1;
            conv_ok_q  <= 1'b0;
         end else if (cvt_done) begin
            conv_ok_q  <= 1'b1;
         end
      end
   end

   assign blank_o      = blank_q;
   assign bcd_o        = blank_q ? {DIGITS{BLANK_NIBBLE}} : cvt_bcd;
   assign bcd_valid_o  = (blank_q == blank_now) &&
                         (blank_q || ((conv_ok_q || cvt_done) && !mismatch));
   assign new_record_o = new_record_q;
   assign last_rank_o  = last_rank_q;

endmodule

// File: tb/tb_game_timer_board.sv
// Self-checking bench for game_timer_board: vector tables plus scoreboarded display/commit checks.
module tb_game_timer_board;
   localparam int TICK_DIV = 4;
   localparam int DIGITS   = 4;
   localparam int SEC_W    = 14;
   localparam int RANKS    = 3;
   localparam int WAIT_MAX = 3 * (SEC_W + 3);

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        run = 1'b0;
   logic        clear = 1'b0;
   logic        commit = 1'b0;
   logic [3:0]  sel = 4'd0;
   logic [15:0] bcd;
   logic        blank, bcd_valid, new_record;
   logic [3:0]  last_rank;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct packed {logic [13:0] val; logic [3:0] rank; logic nr;} commit_vec_t;
   typedef struct packed {logic [3:0] rank; logic nr;} commit_exp_t;
   typedef struct packed {logic [3:0] sel; logic blank; logic [15:0] bcd;} disp_vec_t;

   commit_vec_t cvec [5];
   disp_vec_t   dvec [7];
   commit_exp_t commit_sb [$];
   disp_vec_t   disp_sb [$];

   always #5 clk = ~clk;

   game_timer_board #(
      .TICK_DIV (TICK_DIV),
      .DIGITS   (DIGITS),
      .SEC_W    (SEC_W),
      .RANKS    (RANKS)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .run_i        (run),
      .clear_i      (clear),
      .commit_i     (commit),
      .sel_i        (sel),
      .bcd_o        (bcd),
      .blank_o      (blank),
      .bcd_valid_o  (bcd_valid),
      .new_record_o (new_record),
      .last_rank_o  (last_rank)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Drive sel, queue the expected display, then wait (bounded) for bcd_valid and compare.
   task automatic show(input logic [3:0] s, input logic b, input logic [15:0] v);
      disp_vec_t e;
      bit seen;
      e = '{sel: s, blank: b, bcd: v};
      sel = s;
      disp_sb.push_back(e);
      seen = 1'b0;
      for (int i = 0; i < WAIT_MAX && !seen; i++) begin
         @(negedge clk);
         seen = bcd_valid;
      end
      e = disp_sb.pop_front();
      check($sformatf("bcd_valid sel=%0d", e.sel), 32'(seen), 32'd1);
      check($sformatf("blank sel=%0d", e.sel), 32'(blank), 32'(e.blank));
      check($sformatf("bcd sel=%0d", e.sel), 32'(bcd), 32'(e.bcd));
   endtask

   task automatic run_to(input int v);
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      run   = 1'b1;
      repeat (TICK_DIV * v) @(negedge clk);
      run = 1'b0;
   endtask

   task automatic do_commit(input logic [3:0] rank, input logic nr, input logic with_clear);
      commit_exp_t e;
      e = '{rank: rank, nr: nr};
      commit = 1'b1;
      clear  = with_clear;
      commit_sb.push_back(e);
      @(negedge clk);
      commit = 1'b0;
      clear  = 1'b0;
      e = commit_sb.pop_front();
      check("last_rank", 32'(last_rank), 32'(e.rank));
      check("new_record", 32'(new_record), 32'(e.nr));
      @(negedge clk);
      check("new_record pulse width", 32'(new_record), 32'd0);
   endtask

   // Release reset at a negedge; the first conversion must complete exactly SEC_W+2 edges later.
   task automatic release_and_measure(input string tag);
      rst = 1'b0;
      for (int k = 1; k <= SEC_W + 2; k++) begin
         @(negedge clk);
         if (k == SEC_W + 1) check({tag, " valid early"}, 32'(bcd_valid), 32'd0);
      end
      check({tag, " valid at latency"}, 32'(bcd_valid), 32'd1);
      check({tag, " bcd"}, 32'(bcd), 32'h0000);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      cvec[0] = '{val: 14'd30, rank: 4'd1, nr: 1'b1};
      cvec[1] = '{val: 14'd12, rank: 4'd1, nr: 1'b1};
      cvec[2] = '{val: 14'd30, rank: 4'd3, nr: 1'b0};
      cvec[3] = '{val: 14'd50, rank: 4'd0, nr: 1'b0};
      cvec[4] = '{val: 14'd7,  rank: 4'd1, nr: 1'b1};

      dvec[0] = '{sel: 4'd1,  blank: 1'b0, bcd: 16'h0007};
      dvec[1] = '{sel: 4'd2,  blank: 1'b0, bcd: 16'h0012};
      dvec[2] = '{sel: 4'd3,  blank: 1'b0, bcd: 16'h0030};
      dvec[3] = '{sel: 4'd0,  blank: 1'b0, bcd: 16'h0007};
      dvec[4] = '{sel: 4'd9,  blank: 1'b1, bcd: 16'hFFFF};
      dvec[5] = '{sel: 4'd4,  blank: 1'b1, bcd: 16'hFFFF};
      dvec[6] = '{sel: 4'd15, blank: 1'b1, bcd: 16'hFFFF};

      repeat (2) @(negedge clk);
      check("reset bcd", 32'(bcd), 32'h0000);
      check("reset bcd_valid", 32'(bcd_valid), 32'd0);
      check("reset blank", 32'(blank), 32'd0);
      check("reset new_record", 32'(new_record), 32'd0);
      check("reset last_rank", 32'(last_rank), 32'd0);

      release_and_measure("first release");

      show(4'd2, 1'b1, 16'hFFFF);
      show(4'd9, 1'b1, 16'hFFFF);
      show(4'd0, 1'b0, 16'h0000);

      run = 1'b1;
      repeat (40) @(negedge clk);
      run = 1'b0;
      show(4'd0, 1'b0, 16'h0010);

      for (int i = 0; i < 5; i++) begin
         run_to(int'(cvec[i].val));
         do_commit(cvec[i].rank, cvec[i].nr, 1'b0);
      end

      for (int i = 0; i < 7; i++) show(dvec[i].sel, dvec[i].blank, dvec[i].bcd);

      sel = 4'd0;
      run_to(25);
      do_commit(4'd3, 1'b0, 1'b1);
      show(4'd0, 1'b0, 16'h0000);
      show(4'd3, 1'b0, 16'h0025);
      show(4'd2, 1'b0, 16'h0012);

      sel = 4'd0;
      run_to(9999 + 3);
      show(4'd0, 1'b0, 16'h9999);

      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      #1;
      check("mid-shift reset bcd", 32'(bcd), 32'h0000);
      check("mid-shift reset bcd_valid", 32'(bcd_valid), 32'd0);
      check("mid-shift reset blank", 32'(blank), 32'd0);
      check("mid-shift reset new_record", 32'(new_record), 32'd0);
      check("mid-shift reset last_rank", 32'(last_rank), 32'd0);
      @(negedge clk);
      release_and_measure("mid-shift release");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
